// File: rtl/pipe_stage_skid_reg_pkg.sv
// ---------------------------------------------------------------------------
// pipe_stage_skid_reg_pkg
// Shared definitions for the handshaked pipeline stage register.
//   DEF_PC_W / DEF_INSTR_W : default field widths of the stage payload
//   DEF_NOP_INSTR          : bubble instruction loaded on reset/flush
//   stage_payload_t        : {pc, instr} payload at default widths
//   occ_state_t            : occupancy of the 2-entry stage (EMPTY/ONE/TWO)
// ---------------------------------------------------------------------------
package pipe_stage_skid_reg_pkg;

    localparam int          DEF_PC_W      = 32;
    localparam int          DEF_INSTR_W   = 32;
    localparam logic [31:0] DEF_NOP_INSTR = 32'h0000_0000;

    typedef struct packed {
        logic [DEF_PC_W-1:0]    pc;
        logic [DEF_INSTR_W-1:0] instr;
    } stage_payload_t;

    typedef enum logic [1:0] {
        OCC_EMPTY = 2'd0,
        OCC_ONE   = 2'd1,
        OCC_TWO   = 2'd2
    } occ_state_t;

endpackage

// File: rtl/pipe_stage_skid_reg_if.sv
// ---------------------------------------------------------------------------
// pipe_stage_skid_reg_if
// Handshake bundle around one pipeline stage register.
//   in_valid/in_ready/in_pc/in_instr     : upstream side (into the stage)
//   out_valid/out_ready/out_pc/out_instr : downstream side (out of the stage)
// Modports:
//   slave  : the stage register itself
//   master : the surrounding environment (upstream producer + downstream consumer)
// ---------------------------------------------------------------------------
interface pipe_stage_skid_reg_if #(
    parameter int PC_W    = 32,
    parameter int INSTR_W = 32
);
    logic               in_valid;
    logic               in_ready;
    logic [PC_W-1:0]    in_pc;
    logic [INSTR_W-1:0] in_instr;
    logic               out_valid;
    logic               out_ready;
    logic [PC_W-1:0]    out_pc;
    logic [INSTR_W-1:0] out_instr;

    modport slave (
        input  in_valid, in_pc, in_instr, out_ready,
        output in_ready, out_valid, out_pc, out_instr
    );

    modport master (
        output in_valid, in_pc, in_instr, out_ready,
        input  in_ready, out_valid, out_pc, out_instr
    );
endinterface

// File: rtl/pipe_stage_skid_reg_entry.sv
// ---------------------------------------------------------------------------
// pipe_skid_entry
// One payload register with a valid bit, used for both the main and the
// skid slot of the stage.
//   clk        : clock
//   rst        : synchronous reset, active-low
//   i_clear    : drop contents -> valid=0, data=CLEAR_VAL (bubble)
//   i_load     : capture i_data this cycle
//   i_valid_d  : next value of the valid bit (ignored on clear)
//   i_data     : payload to capture
//   o_valid    : registered valid
//   o_data     : registered payload
// ---------------------------------------------------------------------------
module pipe_skid_entry
    import pipe_stage_skid_reg_pkg::*;
#(
    parameter int           W         = DEF_PC_W + DEF_INSTR_W,
    parameter logic [W-1:0] CLEAR_VAL = '0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_clear,
    input  logic         i_load,
    input  logic         i_valid_d,
    input  logic [W-1:0] i_data,
    output logic         o_valid,
    output logic [W-1:0] o_data
);

    logic         r_valid;
    logic [W-1:0] r_data;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_valid <= 1'b0;
            r_data  <= CLEAR_VAL;
        end else if (i_clear) begin
            r_valid <= 1'b0;
            r_data  <= CLEAR_VAL;
        end else begin
            r_valid <= i_valid_d;
            if (i_load) begin
                r_data <= i_data;
            end
        end
    end

    assign o_valid = r_valid;
    assign o_data  = r_data;

endmodule

// File: rtl/pipe_stage_skid_reg.sv
// ---------------------------------------------------------------------------
// pipe_stage_skid_reg
// Pipeline stage register carrying {PC, instruction} with a valid/ready
// handshake. A main + skid entry pair sustains one transfer per cycle while
// in_ready stays a registered signal (it only depends on the skid entry
// being empty, gated by freeze/flush).
//
// Ports:
//   clk        : clock, all logic on posedge
//   rst        : synchronous reset, active-low
//   freeze     : stall, no handshake completes, state/data hold
//   flush      : drop both entries, output data returns to the bubble
//   bus        : handshake bundle (slave modport), see pipe_stage_skid_reg_if
//   stall_cnt  : stall cycle counter   (PIPE_STAGE_PERF_EN only)
//   flush_cnt  : flush cycle counter   (PIPE_STAGE_PERF_EN only)
//
// Build option:
//   PIPE_STAGE_PERF_EN : adds saturating stall_cnt / flush_cnt counters.
//
// Priority: rst > flush > freeze > handshake.
// ---------------------------------------------------------------------------
module pipe_stage_skid_reg
    import pipe_stage_skid_reg_pkg::*;
#(
    parameter int                 PC_W      = DEF_PC_W,
    parameter int                 INSTR_W   = DEF_INSTR_W,
    parameter logic [INSTR_W-1:0] NOP_INSTR = INSTR_W'(DEF_NOP_INSTR),
    parameter int                 CNT_W     = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  freeze,
    input  logic                  flush,
`ifdef PIPE_STAGE_PERF_EN
    pipe_stage_skid_reg_if.slave  bus,
    output logic [CNT_W-1:0]      stall_cnt,
    output logic [CNT_W-1:0]      flush_cnt
`else
    pipe_stage_skid_reg_if.slave  bus
`endif
);

    localparam int                 PAY_W  = PC_W + INSTR_W;
    localparam logic [PAY_W-1:0]   BUBBLE = {{PC_W{1'b0}}, NOP_INSTR};

    occ_state_t       r_state;
    occ_state_t       w_state_next;
    logic             r_rst_done;

    logic             w_accept;
    logic             w_emit;
    logic             w_clear;
    logic             w_main_load;
    logic             w_main_from_skid;
    logic             w_skid_load;

    logic             w_main_v;
    logic             w_skid_v;
    logic [PAY_W-1:0] w_main_data;
    logic [PAY_W-1:0] w_skid_data;
    logic [PAY_W-1:0] w_in_data;
    logic [PAY_W-1:0] w_main_d;

    // ---------------------------------------------------------------------
    // Handshake. in_ready comes straight from registers (skid valid and the
    // out-of-reset flag) plus the freeze/flush controls, so no combinational
    // path runs from out_ready back to in_ready.
    // ---------------------------------------------------------------------
    assign bus.in_ready  = r_rst_done & ~w_skid_v & ~freeze & ~flush;
    assign bus.out_valid = w_main_v & ~freeze;
    assign bus.out_pc    = w_main_data[PAY_W-1:INSTR_W];
    assign bus.out_instr = w_main_data[INSTR_W-1:0];

    assign w_accept  = bus.in_valid & bus.in_ready;
    assign w_emit    = bus.out_valid & bus.out_ready;
    assign w_in_data = {bus.in_pc, bus.in_instr};

    // Keeps in_ready low for the whole reset cycle.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_rst_done <= 1'b0;
        end else begin
            r_rst_done <= 1'b1;
        end
    end

    // ---------------------------------------------------------------------
    // Occupancy FSM
    // ---------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= OCC_EMPTY;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next     = r_state;
        w_clear          = 1'b0;
        w_main_load      = 1'b0;
        w_main_from_skid = 1'b0;
        w_skid_load      = 1'b0;

        if (flush) begin
            w_clear      = 1'b1;
            w_state_next = OCC_EMPTY;
        end else begin
            // freeze needs no branch: it already forces accept/emit low.
            unique case (r_state)
                OCC_EMPTY: begin
                    if (w_accept) begin
                        w_main_load  = 1'b1;
                        w_state_next = OCC_ONE;
                    end
                end
                OCC_ONE: begin
                    if (w_accept && w_emit) begin
                        w_main_load  = 1'b1;
                    end else if (w_emit) begin
                        w_state_next = OCC_EMPTY;
                    end else if (w_accept) begin
                        // Main is stalled: park the new item in the skid slot.
                        w_skid_load  = 1'b1;
                        w_state_next = OCC_TWO;
                    end
                end
                OCC_TWO: begin
                    // in_ready is low here, so only the drain can happen.
                    if (w_emit) begin
                        w_main_from_skid = 1'b1;
                        w_state_next     = OCC_ONE;
                    end
                end
                default: begin
                    w_state_next = OCC_EMPTY;
                end
            endcase
        end
    end

    assign w_main_d = w_main_from_skid ? w_skid_data : w_in_data;

    // ---------------------------------------------------------------------
    // Storage entries
    // ---------------------------------------------------------------------
    pipe_skid_entry #(
        .W         (PAY_W),
        .CLEAR_VAL (BUBBLE)
    ) u_main (
        .clk       (clk),
        .rst       (rst),
        .i_clear   (w_clear),
        .i_load    (w_main_load | w_main_from_skid),
        .i_valid_d (w_state_next != OCC_EMPTY),
        .i_data    (w_main_d),
        .o_valid   (w_main_v),
        .o_data    (w_main_data)
    );

    pipe_skid_entry #(
        .W         (PAY_W),
        .CLEAR_VAL (BUBBLE)
    ) u_skid (
        .clk       (clk),
        .rst       (rst),
        .i_clear   (w_clear),
        .i_load    (w_skid_load),
        .i_valid_d (w_state_next == OCC_TWO),
        .i_data    (w_in_data),
        .o_valid   (w_skid_v),
        .o_data    (w_skid_data)
    );

`ifdef PIPE_STAGE_PERF_EN
    // ---------------------------------------------------------------------
    // Saturating performance counters: [0] stall cycles, [1] flush cycles.
    // A stall is either an explicit freeze or a held output nobody takes.
    // ---------------------------------------------------------------------
    logic [1:0]       w_cnt_inc;
    logic [CNT_W-1:0] r_cnt [2];

    assign w_cnt_inc[0] = (w_main_v & ~bus.out_ready) | freeze;
    assign w_cnt_inc[1] = flush;

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_perf_cnt
            always_ff @(posedge clk) begin
                if (!rst) begin
                    r_cnt[gi] <= '0;
                end else if (w_cnt_inc[gi] && (r_cnt[gi] != {CNT_W{1'b1}})) begin
                    r_cnt[gi] <= r_cnt[gi] + 1'b1;
                end
            end
        end
    endgenerate

    assign stall_cnt = r_cnt[0];
    assign flush_cnt = r_cnt[1];
`endif

endmodule

// File: tb/tb_pipe_stage_skid_reg.sv
// ---------------------------------------------------------------------------
// tb_pipe_stage_skid_reg
// Directed bench for pipe_stage_skid_reg. Inputs change on the falling edge,
// outputs are checked 1 time unit later, so every check sees the state left
// by the previous rising edge combined with the inputs of the current cycle.
// ---------------------------------------------------------------------------
module tb_pipe_stage_skid_reg;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic clk;
    logic rst;
    logic freeze;
    logic flush;

    int checks;
    int errors;

    pipe_stage_skid_reg_if #(.PC_W(32), .INSTR_W(32)) bus ();

`ifdef PIPE_STAGE_PERF_EN
    logic [15:0] stall_cnt;
    logic [15:0] flush_cnt;
    logic [1:0]  stall_cnt2;
    logic [1:0]  flush_cnt2;

    pipe_stage_skid_reg_if #(.PC_W(32), .INSTR_W(32)) bus2 ();

    pipe_stage_skid_reg #(
        .PC_W(32), .INSTR_W(32), .NOP_INSTR(NOP), .CNT_W(16)
    ) dut (
        .clk(clk), .rst(rst), .freeze(freeze), .flush(flush),
        .bus(bus), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    pipe_stage_skid_reg #(
        .PC_W(32), .INSTR_W(32), .NOP_INSTR(NOP), .CNT_W(2)
    ) dut2 (
        .clk(clk), .rst(rst), .freeze(freeze), .flush(flush),
        .bus(bus2), .stall_cnt(stall_cnt2), .flush_cnt(flush_cnt2)
    );

    initial begin
        bus2.in_valid  = 1'b0;
        bus2.in_pc     = '0;
        bus2.in_instr  = '0;
        bus2.out_ready = 1'b1;
    end
`else
    pipe_stage_skid_reg #(
        .PC_W(32), .INSTR_W(32), .NOP_INSTR(NOP), .CNT_W(16)
    ) dut (
        .clk(clk), .rst(rst), .freeze(freeze), .flush(flush),
        .bus(bus)
    );
`endif

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic drive(input logic v, input logic [31:0] pc,
                         input logic [31:0] instr, input logic ordy);
        bus.in_valid  = v;
        bus.in_pc     = pc;
        bus.in_instr  = instr;
        bus.out_ready = ordy;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        freeze = 1'b0;
        flush = 1'b0;
        drive(1'b0, 32'h0, 32'h0, 1'b0);
        repeat (2) @(posedge clk);
        @(negedge clk); #1;
        checks++;
        if (bus.out_valid !== 1'b0) begin
            errors++; $display("FAIL rst_out_valid got=%b exp=0", bus.out_valid);
        end
        checks++;
        if (bus.out_instr !== NOP) begin
            errors++; $display("FAIL rst_out_instr got=%h exp=%h", bus.out_instr, NOP);
        end
        checks++;
        if (bus.out_pc !== 32'h0) begin
            errors++; $display("FAIL rst_out_pc got=%h exp=0", bus.out_pc);
        end
        checks++;
        if (bus.in_ready !== 1'b0) begin
            errors++; $display("FAIL rst_in_ready got=%b exp=0", bus.in_ready);
        end
        rst = 1'b1;
        @(negedge clk); #1;
        checks++;
        if (bus.in_ready !== 1'b1) begin
            errors++; $display("FAIL rst_release_in_ready got=%b exp=1", bus.in_ready);
        end
        $display("reset: out_valid=%b out_pc=%h out_instr=%h in_ready=%b",
                 bus.out_valid, bus.out_pc, bus.out_instr, bus.in_ready);
    endtask

    task automatic test_stream();
        logic [31:0] pcs [3];
        logic [31:0] ins [3];
        pcs[0] = 32'h100; pcs[1] = 32'h104; pcs[2] = 32'h108;
        ins[0] = 32'h11;  ins[1] = 32'h22;  ins[2] = 32'h33;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (i < 3) drive(1'b1, pcs[i], ins[i], 1'b1);
            else       drive(1'b0, 32'h0, 32'h0, 1'b1);
            #1;
            checks++;
            if (bus.in_ready !== 1'b1) begin
                errors++; $display("FAIL stream_in_ready cyc=%0d got=%b exp=1", i, bus.in_ready);
            end
            if (i >= 1 && i <= 3) begin
                checks++;
                if (bus.out_valid !== 1'b1 || bus.out_pc !== pcs[i-1] || bus.out_instr !== ins[i-1]) begin
                    errors++;
                    $display("FAIL stream_out cyc=%0d got v=%b pc=%h ins=%h exp v=1 pc=%h ins=%h",
                             i, bus.out_valid, bus.out_pc, bus.out_instr, pcs[i-1], ins[i-1]);
                end
                $display("stream: emit pc=%h instr=%h", bus.out_pc, bus.out_instr);
            end else begin
                checks++;
                if (bus.out_valid !== 1'b0) begin
                    errors++; $display("FAIL stream_idle cyc=%0d got=%b exp=0", i, bus.out_valid);
                end
            end
        end
    endtask

    task automatic test_backpressure();
        // Two accepts with the consumer stalled fill main and skid.
        @(negedge clk); drive(1'b1, 32'h200, 32'hA0, 1'b0); #1;
        checks++;
        if (bus.in_ready !== 1'b1) begin
            errors++; $display("FAIL bp_rdy0 got=%b exp=1", bus.in_ready);
        end
        @(negedge clk); drive(1'b1, 32'h204, 32'hA4, 1'b0); #1;
        checks++;
        if (bus.in_ready !== 1'b1) begin
            errors++; $display("FAIL bp_rdy1 got=%b exp=1", bus.in_ready);
        end
        // Full: a third item must be refused while the head holds.
        for (int i = 0; i < 2; i++) begin
            @(negedge clk); drive(1'b1, 32'h208, 32'hA8, 1'b0); #1;
            checks++;
            if (bus.in_ready !== 1'b0 || bus.out_valid !== 1'b1 || bus.out_pc !== 32'h200) begin
                errors++;
                $display("FAIL bp_full cyc=%0d got rdy=%b v=%b pc=%h exp rdy=0 v=1 pc=200",
                         i, bus.in_ready, bus.out_valid, bus.out_pc);
            end
        end
        @(negedge clk); drive(1'b0, 32'h0, 32'h0, 1'b1); #1;
        checks++;
        if (bus.out_valid !== 1'b1 || bus.out_pc !== 32'h200 || bus.out_instr !== 32'hA0) begin
            errors++;
            $display("FAIL bp_first got v=%b pc=%h ins=%h exp v=1 pc=200 ins=a0",
                     bus.out_valid, bus.out_pc, bus.out_instr);
        end
        $display("backpressure: emit pc=%h", bus.out_pc);
        @(negedge clk); #1;
        checks++;
        if (bus.out_valid !== 1'b1 || bus.out_pc !== 32'h204 || bus.out_instr !== 32'hA4
            || bus.in_ready !== 1'b1) begin
            errors++;
            $display("FAIL bp_second got v=%b pc=%h ins=%h rdy=%b exp v=1 pc=204 ins=a4 rdy=1",
                     bus.out_valid, bus.out_pc, bus.out_instr, bus.in_ready);
        end
        $display("backpressure: emit pc=%h", bus.out_pc);
        @(negedge clk); #1;
        checks++;
        if (bus.out_valid !== 1'b0) begin
            errors++; $display("FAIL bp_drained got=%b exp=0", bus.out_valid);
        end
    endtask

    task automatic test_freeze();
        @(negedge clk); drive(1'b1, 32'h300, 32'hB0, 1'b0);
        @(negedge clk);
        freeze = 1'b1;
        drive(1'b1, 32'h304, 32'hB4, 1'b1);
        for (int i = 0; i < 3; i++) begin
            if (i > 0) @(negedge clk);
            #1;
            checks++;
            if (bus.in_ready !== 1'b0 || bus.out_valid !== 1'b0
                || bus.out_pc !== 32'h300 || bus.out_instr !== 32'hB0) begin
                errors++;
                $display("FAIL freeze_hold cyc=%0d got rdy=%b v=%b pc=%h ins=%h exp rdy=0 v=0 pc=300 ins=b0",
                         i, bus.in_ready, bus.out_valid, bus.out_pc, bus.out_instr);
            end
        end
        @(negedge clk);
        freeze = 1'b0;
        #1;
        checks++;
        if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b1 || bus.out_pc !== 32'h300) begin
            errors++;
            $display("FAIL freeze_resume got rdy=%b v=%b pc=%h exp rdy=1 v=1 pc=300",
                     bus.in_ready, bus.out_valid, bus.out_pc);
        end
        $display("freeze: emit pc=%h", bus.out_pc);
        @(negedge clk); drive(1'b0, 32'h0, 32'h0, 1'b1); #1;
        checks++;
        if (bus.out_valid !== 1'b1 || bus.out_pc !== 32'h304 || bus.out_instr !== 32'hB4) begin
            errors++;
            $display("FAIL freeze_next got v=%b pc=%h ins=%h exp v=1 pc=304 ins=b4",
                     bus.out_valid, bus.out_pc, bus.out_instr);
        end
        $display("freeze: emit pc=%h", bus.out_pc);
        @(negedge clk); #1;
    endtask

    task automatic test_flush();
        @(negedge clk); drive(1'b1, 32'h400, 32'hC0, 1'b0);
        @(negedge clk); drive(1'b1, 32'h404, 32'hC4, 1'b0);
        @(negedge clk);
        flush = 1'b1;
        drive(1'b1, 32'h408, 32'hC8, 1'b0);
        #1;
        checks++;
        if (bus.in_ready !== 1'b0) begin
            errors++; $display("FAIL flush_in_ready got=%b exp=0", bus.in_ready);
        end
        @(negedge clk);
        flush = 1'b0;
        drive(1'b0, 32'h0, 32'h0, 1'b1);
        #1;
        checks++;
        if (bus.out_valid !== 1'b0 || bus.out_instr !== NOP || bus.out_pc !== 32'h0
            || bus.in_ready !== 1'b1) begin
            errors++;
            $display("FAIL flush_after got v=%b pc=%h ins=%h rdy=%b exp v=0 pc=0 ins=%h rdy=1",
                     bus.out_valid, bus.out_pc, bus.out_instr, bus.in_ready, NOP);
        end
        $display("flush: out_valid=%b out_instr=%h", bus.out_valid, bus.out_instr);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); #1;
            checks++;
            if (bus.out_valid !== 1'b0) begin
                errors++;
                $display("FAIL flush_ghost cyc=%0d got v=%b pc=%h exp v=0", i, bus.out_valid, bus.out_pc);
            end
        end
    endtask

`ifdef PIPE_STAGE_PERF_EN
    task automatic test_perf();
        @(negedge clk); rst = 1'b0; drive(1'b0, 32'h0, 32'h0, 1'b1);
        @(negedge clk); rst = 1'b1; #1;
        checks++;
        if (stall_cnt !== 16'd0 || flush_cnt !== 16'd0) begin
            errors++; $display("FAIL perf_clear got s=%0d f=%0d exp 0 0", stall_cnt, flush_cnt);
        end
        for (int i = 0; i < 5; i++) begin
            @(negedge clk); freeze = 1'b1;
        end
        @(negedge clk); freeze = 1'b0; #1;
        checks++;
        if (stall_cnt !== 16'd5) begin
            errors++; $display("FAIL perf_stall got=%0d exp=5", stall_cnt);
        end
        checks++;
        if (stall_cnt2 !== 2'd3) begin
            errors++; $display("FAIL perf_sat5 got=%0d exp=3", stall_cnt2);
        end
        for (int i = 0; i < 2; i++) begin
            @(negedge clk); flush = 1'b1;
        end
        @(negedge clk); flush = 1'b0; #1;
        checks++;
        if (flush_cnt !== 16'd2 || stall_cnt !== 16'd5) begin
            errors++; $display("FAIL perf_flush got f=%0d s=%0d exp f=2 s=5", flush_cnt, stall_cnt);
        end
        @(negedge clk); freeze = 1'b1;
        @(negedge clk); freeze = 1'b0; #1;
        checks++;
        if (stall_cnt !== 16'd6 || stall_cnt2 !== 2'd3) begin
            errors++; $display("FAIL perf_sat6 got s=%0d s2=%0d exp s=6 s2=3", stall_cnt, stall_cnt2);
        end
        $display("perf: stall_cnt=%0d flush_cnt=%0d stall_cnt2=%0d", stall_cnt, flush_cnt, stall_cnt2);
    endtask
`endif

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_stream();
        test_backpressure();
        test_freeze();
        test_flush();
`ifdef PIPE_STAGE_PERF_EN
        test_perf();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
